// File: rtl/wb_stream_fifo_ingress_if.sv
// ---------------------------------------------------------------------------
// wb_stream_fifo_ingress_if
// Bundles the producer-side valid/ready stream and the consumer-side FIFO
// read port of wb_stream_fifo_ingress.
//
// Signals:
//   s_data_i  [WB_DW]   stream data from producer
//   s_valid_i           stream data valid
//   s_ready_o           FIFO can accept a word this cycle
//   fifo_d    [WB_DW]   head-of-FIFO word (show-ahead)
//   fifo_dv             FIFO non-empty, fifo_d valid
//   fifo_cnt  [FIFO_AW] current fill level
//   fifo_rd             pop head word
//
// Modports:
//   slave  - the FIFO itself (consumes stream, serves reads)
//   master - the surrounding logic (producer + burst controller)
// ---------------------------------------------------------------------------
interface wb_stream_fifo_ingress_if #(
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 4
);
    logic [WB_DW-1:0]   s_data_i;
    logic               s_valid_i;
    logic               s_ready_o;
    logic [WB_DW-1:0]   fifo_d;
    logic               fifo_dv;
    logic [FIFO_AW-1:0] fifo_cnt;
    logic               fifo_rd;

    modport slave (
        input  s_data_i,
        input  s_valid_i,
        output s_ready_o,
        output fifo_d,
        output fifo_dv,
        output fifo_cnt,
        input  fifo_rd
    );

    modport master (
        output s_data_i,
        output s_valid_i,
        input  s_ready_o,
        input  fifo_d,
        input  fifo_dv,
        input  fifo_cnt,
        output fifo_rd
    );
endinterface

// File: rtl/wb_stream_fifo_ingress.sv
// ---------------------------------------------------------------------------
// wb_stream_fifo_ingress
// Upstream stage of the Wishbone stream writer. Buffers a valid/ready stream
// in a show-ahead FIFO of 2^FIFO_AW - 1 usable entries and presents the head
// word, a data-valid flag and the fill count to the burst controller.
// Also provides flush, sticky overflow/underflow flags and a high-water mark.
//
// Ports:
//   wb_clk_i     system clock, rising edge
//   wb_rst_ni    asynchronous active-low reset
//   bus          stream + FIFO read port (slave modport)
//   flush_i      synchronous clear of FIFO contents (beats push/pop)
//   clr_flags_i  clear sticky flags and high-water mark
//   overflow_o   sticky: s_valid_i seen while s_ready_o low
//   underflow_o  sticky: fifo_rd seen while empty
//   hwm_o        highest fill count since reset / clear
// ---------------------------------------------------------------------------
module wb_stream_fifo_ingress #(
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 4
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    wb_stream_fifo_ingress_if.slave     bus,
    input  logic                        flush_i,
    input  logic                        clr_flags_i,
    output logic                        overflow_o,
    output logic                        underflow_o,
    output logic [FIFO_AW-1:0]          hwm_o
);

    generate
        if (FIFO_AW < 2) begin : g_bad_aw
            $error("wb_stream_fifo_ingress: FIFO_AW must be >= 2");
        end
    endgenerate

    localparam int                 DEPTH = 1 << FIFO_AW;
    // Usable capacity is one less than the array size so the count fits in
    // FIFO_AW bits; all-ones is the full level.
    localparam logic [FIFO_AW-1:0] CAP   = '1;

    logic [WB_DW-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] cnt_q,    cnt_d;
    logic               ovf_q,    ovf_d;
    logic               unf_q,    unf_d;
    logic [FIFO_AW-1:0] hwm_q,    hwm_d;
    logic [FIFO_AW-1:0] hwm_base;

    logic ready;
    logic dv;
    logic push;
    logic pop;

    // Status comes from the registered count only, so fifo_rd never reaches
    // s_ready_o combinationally; a pop at full frees the slot next cycle.
    assign ready = (cnt_q != CAP);
    assign dv    = (cnt_q != '0);
    assign push  = bus.s_valid_i & ready;
    assign pop   = bus.fifo_rd & dv;

    assign bus.s_ready_o = ready;
    assign bus.fifo_dv   = dv;
    assign bus.fifo_cnt  = cnt_q;
    assign bus.fifo_d    = mem_q[rd_ptr_q];

    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign hwm_o       = hwm_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + FIFO_AW'(1);
                2'b01:   cnt_d = cnt_q - FIFO_AW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // Clear first, then let a same-cycle event re-set the flag.
        ovf_d = (clr_flags_i ? 1'b0 : ovf_q) | (bus.s_valid_i & ~ready);
        unf_d = (clr_flags_i ? 1'b0 : unf_q) | (bus.fifo_rd & ~dv);

        hwm_base = clr_flags_i ? '0 : hwm_q;
        hwm_d    = (cnt_d > hwm_base) ? cnt_d : hwm_base;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            hwm_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            hwm_q    <= hwm_d;
        end
    end

    // Storage has no reset; contents are only observed while fifo_dv is high.
    always_ff @(posedge wb_clk_i) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= bus.s_data_i;
        end
    end

endmodule
